// File: rtl/screen_pkg.sv
// Shared screen-rendering definitions.
//   render_state_t : cell_renderer FSM states
//   GLYPH_W        : edge length of the square digit glyph, in pixels
package screen;

  localparam int GLYPH_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_ROW = 2'd1,
    DRAW     = 2'd2,
    DONE     = 2'd3
  } render_state_t;

endpackage

// File: rtl/digit_font_rom.sv
// 8x8 digit font ROM with a registered output (one-cycle latency).
//   clk, rst : clock, asynchronous active-high reset
//   digit    : digit to look up; 1-9 hold glyphs, 0 and 10-15 are blank
//   row      : glyph row, 0 = top
//   bits     : glyph row pixels, bit 7 = leftmost pixel
module digit_font_rom (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic [2:0] row,
  output logic [7:0] bits
);

  logic [63:0] glyph;   // row 0 in [63:56]
  logic [7:0]  bits_d;
  logic [7:0]  bits_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    glyph = 64'h0;
    case (digit)
      4'd1:    glyph = 64'h1838_1818_1818_7E00;
      4'd2:    glyph = 64'h3C66_060C_3060_7E00;
      4'd3:    glyph = 64'h3C66_061C_0666_3C00;
      4'd4:    glyph = 64'h0C1C_3C6C_7E0C_0C00;
      4'd5:    glyph = 64'h7E60_7C06_0666_3C00;
      4'd6:    glyph = 64'h3C60_7C66_6666_3C00;
      4'd7:    glyph = 64'h7E06_0C18_3030_3000;
      4'd8:    glyph = 64'h3C66_663C_6666_3C00;
      4'd9:    glyph = 64'h3C66_663E_060C_3800;
      default: glyph = 64'h0;
    endcase
    bits_d = glyph[8*(7-int'(row)) +: 8];
  end

  // NOTE: this is a single output register, not a memory array, so it can take a reset cheaply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bits_q <= 8'h00;
    else     bits_q <= bits_d;
  end

  assign bits = bits_q;

endmodule

// File: rtl/cell_renderer.sv
// Rasterises one Sudoku cell into a CELL_PX x CELL_PX tile: top/left border,
// background fill and a centred 8x8 digit glyph, streamed in raster order.
//   clk, rst                       : clock, asynchronous active-high reset
//   start_cell, cell_row/col/data  : render request (sampled only in IDLE)
//   pix_ready                      : downstream accepts the current pixel
//   pix_valid, pix_x/y, pix_color  : registered pixel stream
//   busy                           : tile in progress (LOAD_ROW..DONE)
//   done                           : one-cycle pulse when the tile is complete
module cell_renderer
  import screen::*;
#(
  parameter int          CELL_PX      = 16,
  parameter int          COORD_W      = 9,
  parameter logic [15:0] FG_COLOR     = 16'hFFFF,
  parameter logic [15:0] BG_COLOR     = 16'h0000,
  parameter logic [15:0] BORDER_COLOR = 16'h7BEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_cell,
  input  logic [3:0]         cell_row,
  input  logic [3:0]         cell_col,
  input  logic [3:0]         cell_data,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_color,
  output logic               busy,
  output logic               done
);

  localparam int GOFF = (CELL_PX - GLYPH_W) / 2;
  localparam int PX_W = $clog2(CELL_PX);
  localparam logic [PX_W-1:0] LAST = PX_W'(CELL_PX - 1);

  render_state_t      state_q, state_d;
  logic [PX_W-1:0]    px_q, px_d, py_q, py_d;
  logic [3:0]         data_q, data_d;
  logic [COORD_W-1:0] base_x_q, base_x_d, base_y_q, base_y_d;
  logic               pix_valid_q, pix_valid_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]        pix_color_q, pix_color_d;
  logic [7:0]         glyph_bits;

  // The ROM address depends only on py, which is constant across a DRAW row,
  // so the registered ROM output is valid for the whole row.
  digit_font_rom u_font (
    .clk   (clk),
    .rst   (rst),
    .digit (data_q),
    .row   (3'(int'(py_q) - GOFF)),
    .bits  (glyph_bits)
  );

  function automatic logic [15:0] pick_color(input logic [PX_W-1:0] x,
                                             input logic [PX_W-1:0] y,
                                             input logic [7:0]      bits);
    logic [2:0] k;
    k = 3'(int'(x) - GOFF);
    if (x == '0 || y == '0) return BORDER_COLOR;
    if (int'(x) >= GOFF && int'(x) < GOFF + GLYPH_W &&
        int'(y) >= GOFF && int'(y) < GOFF + GLYPH_W && bits[3'd7 - k])
      return FG_COLOR;
    return BG_COLOR;
  endfunction

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    data_d      = data_q;
    base_x_d    = base_x_q;
    base_y_d    = base_y_q;
    pix_valid_d = pix_valid_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    case (state_q)
      IDLE: begin
        if (start_cell) begin
          base_x_d = COORD_W'(cell_col) * COORD_W'(CELL_PX);
          base_y_d = COORD_W'(cell_row) * COORD_W'(CELL_PX);
          data_d   = cell_data;
          px_d     = '0;
          py_d     = '0;
          state_d  = LOAD_ROW;
        end
      end
      LOAD_ROW: begin
        // Column 0 is always border, so the first beat of a row needs no glyph data.
        state_d     = DRAW;
        pix_valid_d = 1'b1;
        pix_x_d     = base_x_q;
        pix_y_d     = base_y_q + COORD_W'(py_q);
        pix_color_d = BORDER_COLOR;
      end
      DRAW: begin
        if (pix_ready) begin
          if (px_q == LAST) begin
            px_d        = '0;
            pix_valid_d = 1'b0;
            if (py_q < LAST) begin
              py_d    = py_q + PX_W'(1);
              state_d = LOAD_ROW;
            end else begin
              state_d = DONE;
            end
          end else begin
            px_d        = px_q + PX_W'(1);
            pix_x_d     = pix_x_q + COORD_W'(1);
            pix_color_d = pick_color(px_q + PX_W'(1), py_q, glyph_bits);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      px_q        <= '0;
      py_q        <= '0;
      data_q      <= '0;
      base_x_q    <= '0;
      base_y_q    <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      data_q      <= data_d;
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
    end
  end

  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_cell_renderer.sv
module tb_cell_renderer;

  localparam logic [15:0] FG  = 16'hFFFF;
  localparam logic [15:0] BG  = 16'h0000;
  localparam logic [15:0] BRD = 16'h7BEF;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       start_cell = 1'b0;
  logic [3:0] cell_row = '0, cell_col = '0, cell_data = '0;
  logic       pix_ready = 1'b0;
  logic       pix_valid;
  logic [8:0] pix_x, pix_y;
  logic [15:0] pix_color;
  logic       busy, done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] c;
  } pix_t;
  pix_t exp_q[$];

  always #5 if (clk_en) clk = ~clk;

  cell_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .start_cell (start_cell),
    .cell_row   (cell_row),
    .cell_col   (cell_col),
    .cell_data  (cell_data),
    .pix_ready  (pix_ready),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .busy       (busy),
    .done       (done)
  );

  // Reference glyph for digit 1; every other digit the bench uses is blank.
  function automatic logic [7:0] glyph_row(input int d, input int r);
    if (d != 1 || r < 0 || r > 7) return 8'h00;
    case (r)
      0: return 8'h18;
      1: return 8'h38;
      6: return 8'h7E;
      7: return 8'h00;
      default: return 8'h18;
    endcase
  endfunction

  task automatic push_tile(input int row, input int col, input int data);
    pix_t e;
    logic [7:0] g;
    for (int py = 0; py < 16; py++) begin
      g = glyph_row(data, py - 4);
      for (int px = 0; px < 16; px++) begin
        e.x = 9'(col * 16 + px);
        e.y = 9'(row * 16 + py);
        if (px == 0 || py == 0)                   e.c = BRD;
        else if (px >= 4 && px < 12 && g[11 - px]) e.c = FG;
        else                                      e.c = BG;
        exp_q.push_back(e);
      end
    end
  endtask

  // Runs from the negedge after the accept edge; cycle 1 = first cycle after it.
  task automatic drain(input int mode, input bit hold, input int limit,
                       output int first_cyc, output int done_cyc);
    pix_t e;
    bit stall_prev;
    logic [8:0] sx, sy;
    logic [15:0] sc;
    stall_prev = 0; sx = '0; sy = '0; sc = '0;
    first_cyc = -1;
    done_cyc  = -1;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      if (!hold) start_cell = 1'b0;
      if (stall_prev) begin
        vectors++;
        if (pix_valid !== 1'b1 || pix_x !== sx || pix_y !== sy || pix_color !== sc) begin
          miscompares++;
          $display("FAIL stall_hold cyc %0d: got v=%b (%0d,%0d) %h, want v=1 (%0d,%0d) %h",
                   cyc, pix_valid, pix_x, pix_y, pix_color, sx, sy, sc);
        end
      end
      if (mode == 0) pix_ready = 1'b1;
      else           pix_ready = (cyc % 2 == 0) && ($urandom_range(0, 3) != 0);
      if (pix_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (pix_valid === 1'b1 && pix_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_pixel: got (%0d,%0d) %h, want no pixel", pix_x, pix_y, pix_color);
        end else begin
          e = exp_q.pop_front();
          if (pix_x !== e.x || pix_y !== e.y || pix_color !== e.c) begin
            miscompares++;
            $display("FAIL pixel: got (%0d,%0d) %h, want (%0d,%0d) %h",
                     pix_x, pix_y, pix_color, e.x, e.y, e.c);
          end
        end
      end
      stall_prev = (pix_valid === 1'b1) && !pix_ready;
      sx = pix_x; sy = pix_y; sc = pix_color;
      if (done === 1'b1) begin
        vectors++;
        if (pix_valid !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL done_cycle_flags: got valid=%b busy=%b, want valid=0 busy=1", pix_valid, busy);
        end
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if (pix_valid !== 1'b0 || pix_x !== 9'd0 || pix_y !== 9'd0 || pix_color !== 16'h0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got v=%b x=%0d y=%0d c=%h busy=%b done=%b, want all 0",
               name, pix_valid, pix_x, pix_y, pix_color, busy, done);
    end
  endtask

  // Drive a request at a negedge (DUT in IDLE), render it, check latency.
  task automatic run_tile(input string name, input int row, input int col, input int data,
                          input int mode);
    int first_cyc, done_cyc;
    push_tile(row, col, data);
    @(negedge clk);
    cell_row = 4'(row); cell_col = 4'(col); cell_data = 4'(data);
    start_cell = 1'b1;
    drain(mode, 1'b0, 4000, first_cyc, done_cyc);
    check_int({name, "_first_pixel_cycle"}, first_cyc, 2);
    if (mode == 0) check_int({name, "_done_cycle"}, done_cyc, 273);
    else check_int({name, "_done_seen"}, int'(done_cyc > 273), 1);
    check_int({name, "_pixels_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check_int({name, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #10 check_outputs_zero("reset_no_clock");
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vectors++;
      if (pix_valid !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_quiet cyc %0d: got valid=%b done=%b, want 0 0", i, pix_valid, done);
      end
    end
  endtask

  task automatic test_empty_cell();   run_tile("empty",   0, 0, 0,  0); endtask
  task automatic test_digit_one();    run_tile("digit1",  8, 8, 1,  0); endtask
  task automatic test_invalid_digit(); run_tile("data12", 0, 0, 12, 0); endtask
  task automatic test_stalls();       run_tile("stall",   4, 3, 1,  1); endtask

  task automatic test_back_to_back_reset();
    int first_cyc, done_cyc;
    push_tile(1, 2, 1);
    @(negedge clk);
    cell_row = 4'd1; cell_col = 4'd2; cell_data = 4'd1;
    start_cell = 1'b1;
    drain(0, 1'b1, 4000, first_cyc, done_cyc);
    check_int("b2b_tile1_done_cycle", done_cyc, 273);
    check_int("b2b_tile1_pixels_left", exp_q.size(), 0);
    exp_q.delete();
    // Cycle D+1: IDLE, start still high, accepted at its closing edge.
    @(negedge clk);
    check_int("b2b_idle_busy", int'(busy), 0);
    push_tile(1, 2, 1);
    drain(0, 1'b1, 40, first_cyc, done_cyc);
    check_int("b2b_tile2_first_pixel_D_plus_3", first_cyc, 2);
    check_int("b2b_tile2_no_done_before_reset", done_cyc, -1);
    exp_q.delete();
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_reset_mid_draw");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_int("no_done_in_reset", int'(done), 0);
    end
    rst = 1'b0;
    push_tile(1, 2, 1);
    drain(0, 1'b1, 4000, first_cyc, done_cyc);
    check_int("b2b_tile3_first_pixel_cycle", first_cyc, 2);
    check_int("b2b_tile3_done_cycle", done_cyc, 273);
    check_int("b2b_tile3_pixels_left", exp_q.size(), 0);
    exp_q.delete();
    start_cell = 1'b0;
  endtask

  initial begin
    test_reset();
    test_empty_cell();
    test_digit_one();
    test_invalid_digit();
    test_stalls();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cell_renderer.md
# cell_renderer

Downstream consumer of the board cell scanner. Accepts one Sudoku cell (row, column, digit) per start request and rasterises it into a CELL_PX × CELL_PX pixel tile: a one-pixel border on top and left, background fill, and an 8×8 digit glyph centred in the tile. Pixels leave through a valid/ready stream, in raster order, to the frame-buffer writer. A `done` pulse tells the system state machine that it may advance to the next cell.

## Interface
- `CELL_PX`, 16, tile edge in pixels; must be ≥ GLYPH_W+2
- `COORD_W`, 9, width of the pixel coordinate outputs; must hold 9·CELL_PX−1
- `FG_COLOR`, 16'hFFFF, RGB565 colour of set glyph pixels
- `BG_COLOR`, 16'h0000, RGB565 colour of the tile background
- `BORDER_COLOR`, 16'h7BEF, RGB565 colour of the tile border
- `clk`  in  1  system clock, all logic on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start_cell`  in  1  request to render the cell currently presented
- `cell_row`  in  4  cell row, 0–8
- `cell_col`  in  4  cell column, 0–8
- `cell_data`  in  4  digit; 0 = empty; 1–9 = digit; 10–15 = rendered as empty
- `pix_ready`  in  1  frame-buffer writer accepts the current pixel
- `pix_valid`  out  1  pixel on `pix_x`/`pix_y`/`pix_color` is valid
- `pix_x`  out  COORD_W  absolute x = cell_col·CELL_PX + px
- `pix_y`  out  COORD_W  absolute y = cell_row·CELL_PX + py
- `pix_color`  out  16  RGB565 colour
- `busy`  out  1  high from the cycle after a start is accepted until the DONE cycle, inclusive
- `done`  out  1  single-cycle pulse when the tile is complete

## Operation
- States: IDLE, LOAD_ROW, DRAW, DONE.
- IDLE: when `start_cell`=1 at a rising edge, latch row, col and data, clear px/py, and go to LOAD_ROW. Inputs are not sampled again until the next IDLE.
- LOAD_ROW: present the digit and glyph row (py−GOFF) to the font ROM. Go to DRAW on the next cycle. `pix_valid`=0.
- DRAW: `pix_valid`=1. On `pix_valid && pix_ready`, px increments.
  - After px = CELL_PX−1: px ← 0 and py increments.
  - Go to LOAD_ROW if py < CELL_PX−1, otherwise to DONE.
- DONE: `done`=1 and `pix_valid`=0 for one cycle, then IDLE.
- GOFF = (CELL_PX−GLYPH_W)/2, computed at elaboration.
- Colour selection, in priority order:
  - px==0 or py==0 → BORDER_COLOR
  - GOFF ≤ px,py < GOFF+GLYPH_W and ROM bit (7−(px−GOFF)) set → FG_COLOR (bit 7 is the leftmost pixel)
  - otherwise → BG_COLOR
- Coordinate arithmetic is unsigned, zero-extended to COORD_W. There is no wrap-around: row and column are trusted to be ≤ 8.
- Stall: while `pix_valid && !pix_ready`, `pix_x`, `pix_y` and `pix_color` hold stable.
- `start_cell` seen while not in IDLE is ignored. It is not queued.
- Reset at any time aborts the tile. No `done` is produced, and the next tile starts from (0,0).

## Timing
- Reset values: `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_color`=0, `busy`=0, `done`=0; state IDLE.
- Accept edge E: LOAD_ROW in cycle E+1, first pixel valid in E+2.
- Per pixel row: 1 LOAD_ROW cycle plus CELL_PX accepted beats.
- With `pix_ready` tied high and CELL_PX=16: 16·17 = 272 busy cycles before DONE; `done` is high in cycle E+273.
- Earliest next accept is the IDLE cycle after DONE, giving a minimum 274-cycle cell period.
- `pix_*` outputs are registered; there is no combinational path from `pix_ready` to `pix_valid`.

## Structure
- Shared package `screen`:
  - add `render_state` enum (IDLE, LOAD_ROW, DRAW, DONE)
  - add constant GLYPH_W = 8
- Sub-module `digit_font_rom`:
  - inputs: digit[3:0], glyph row[2:0]; output: bits[7:0]
  - registered, 1-cycle latency
  - digits 1–9 hold glyphs; 0 and 10–15 return 8'h00

## Test plan
- Reset asserted with no clock → all outputs 0. Release, hold `start_cell`=0 for 50 cycles → `pix_valid` and `done` stay 0.
- Start row 0, col 0, data 0, `pix_ready`=1 → 256 pixels covering x,y 0–15 in raster order. Pixels with x==0 or y==0 are 16'h7BEF, all others 16'h0000. `done` at E+273.
- Start row 8, col 8, data 1 → x and y span 128–143. Pixel (132+k, 132+r) is FG exactly when ROM[1][r] bit 7−k is set.
- Start data 12 → identical pixel stream to data 0.
- `pix_ready` toggling 1010… plus random stalls → each of the 256 pixels is delivered exactly once, and outputs are stable during every stall.
- `start_cell` held high continuously, with `rst` pulsed mid-DRAW on the second tile:
  - first tile: `done` at D, next first pixel at D+3
  - after reset: outputs drop to 0 asynchronously and no `done` is produced
  - next tile restarts at px=py=0
